prog_seq: RTL and testbench

- Multi-cycle program sequencer for the single-issue core.
- Owns the program counter and instruction register, and drives instruction-memory reads with a fixed read latency.
- Presents each fetched instruction to decode/execute, then resolves the next PC from ALU flags and the branch offset.
- Implements the start/done handshake with the top-level bench; this is the control layer around the PC datapath.

---
 rtl/prog_seq_pkg.sv | 17 +
 rtl/prog_seq_if.sv | 31 +++
 rtl/prog_seq_next_pc.sv | 20 ++
 rtl/prog_seq.sv | 102 ++++++++++
 tb/tb_prog_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/prog_seq_pkg.sv
// Shared opcode constants and sequencer state encoding for the program sequencer.
package prog_seq_pkg;

  localparam logic [3:0] BRZ  = 4'h1;
  localparam logic [3:0] BRN  = 4'h2;
  localparam logic [3:0] JMP  = 4'h3;
  localparam logic [3:0] HALT = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StExec,
    StHalt
  } seq_state_t;

endpackage

// File: rtl/prog_seq_if.sv
// Sequencer <-> bench/datapath/imem signal bundle.
interface prog_seq_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 9
);

  logic               start;
  logic               stall;
  logic               z;
  logic               neg;
  logic [7:0]         br_off;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_rd;
  logic [PC_W-1:0]    imem_addr;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               done;
  logic [15:0]        instr_cnt;

  modport master (
    input  start, stall, z, neg, br_off, imem_data,
    output imem_rd, imem_addr, pc, instr, instr_valid, done, instr_cnt
  );

  modport slave (
    output start, stall, z, neg, br_off, imem_data,
    input  imem_rd, imem_addr, pc, instr, instr_valid, done, instr_cnt
  );

endinterface

// File: rtl/prog_seq_next_pc.sv
// Combinational next-PC resolution from opcode, ALU flags and branch offset.
module prog_seq_next_pc import prog_seq_pkg::*; #(
  parameter int unsigned PC_W = 16
) (
  input  logic [3:0]      op,
  input  logic            z,
  input  logic            neg,
  input  logic [7:0]      br_off,
  input  logic [PC_W-1:0] pc,
  output logic            taken,
  output logic [PC_W-1:0] npc
);

  always_comb begin
    taken = ((op == BRZ) && z) || ((op == BRN) && neg) || (op == JMP);
    // Sign-extend the offset; the add wraps modulo 2^PC_W.
    npc   = taken ? (pc + PC_W'($signed(br_off))) : (pc + PC_W'(1));
  end

endmodule

// File: rtl/prog_seq.sv
// Multi-cycle program sequencer: FETCH -> WAIT (IMEM_LAT cycles) -> EXEC, with start/done handshake.
module prog_seq import prog_seq_pkg::*; #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned INSTR_W  = 9,
  parameter int unsigned IMEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  prog_seq_if.master bus
);

  localparam logic [1:0] LatInit = 2'(IMEM_LAT - 1);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, npc;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [1:0]         lat_q, lat_d;
  logic [3:0]         op;
  logic               unused_taken;

  assign op = instr_q[INSTR_W-1 -: 4];

  prog_seq_next_pc #(
    .PC_W(PC_W)
  ) u_next_pc (
    .op    (op),
    .z     (bus.z),
    .neg   (bus.neg),
    .br_off(bus.br_off),
    .pc    (pc_q),
    .taken (unused_taken),
    .npc   (npc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          state_d = StFetch;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        lat_d   = LatInit;
        state_d = StWait;
      end
      StWait: begin
        // Read data is only trusted in the final latency cycle.
        if (lat_q == 2'd0) begin
          instr_d = bus.imem_data;
          state_d = StExec;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      StExec: begin
        if (!bus.stall) begin
          cnt_d = cnt_q + 16'd1;
          if (op == HALT) begin
            state_d = StHalt;
          end else begin
            pc_d    = npc;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.imem_rd     = (state_q == StFetch);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == StExec);
  assign bus.done        = (state_q == StHalt);
  assign bus.instr_cnt   = cnt_q;

endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq: one instance at IMEM_LAT=1, one at IMEM_LAT=3, sharing a small imem.
module tb_prog_seq;
  import prog_seq_pkg::*;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 9;
  localparam logic [INSTR_W-1:0] GARBAGE = 9'h1AA;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [INSTR_W-1:0] mem [16];
  logic [7:0]         off_tab [16];

  prog_seq_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) if1 ();
  prog_seq_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) if3 ();

  prog_seq #(.PC_W(PC_W), .INSTR_W(INSTR_W), .IMEM_LAT(1)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (if1)
  );

  prog_seq #(.PC_W(PC_W), .INSTR_W(INSTR_W), .IMEM_LAT(3)) u_dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (if3)
  );

  // Imem models: data valid only in the LAT-th cycle after the read strobe, garbage otherwise.
  logic [2:0]  lc1 = '0;
  logic [2:0]  lc3 = '0;
  logic [15:0] ra1 = '0;
  logic [15:0] ra3 = '0;

  always @(posedge clk) begin
    if (if1.imem_rd) begin
      lc1 <= 3'd1;
      ra1 <= if1.imem_addr;
    end else if (lc1 == 3'd1) lc1 <= 3'd0;
    if (if3.imem_rd) begin
      lc3 <= 3'd1;
      ra3 <= if3.imem_addr;
    end else if (lc3 == 3'd3) lc3 <= 3'd0;
    else if (lc3 != 3'd0) lc3 <= lc3 + 3'd1;
  end

  assign if1.imem_data = (lc1 == 3'd1) ? mem[ra1[3:0]] : GARBAGE;
  assign if3.imem_data = (lc3 == 3'd3) ? mem[ra3[3:0]] : GARBAGE;
  assign if1.br_off    = off_tab[if1.pc[3:0]];
  assign if3.br_off    = off_tab[if3.pc[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd1(input logic [15:0] addr);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!if1.imem_rd && n < 40);
    chk($sformatf("rd1_seen_%0h", addr), {31'd0, if1.imem_rd}, 32'd1);
    chk($sformatf("rd1_addr_%0h", addr), {16'd0, if1.imem_addr}, {16'd0, addr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if1.start = 0; if1.stall = 0; if1.z = 0; if1.neg = 0;
    if3.start = 0; if3.stall = 0; if3.z = 0; if3.neg = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 9'h000;
      off_tab[i] = 8'h7F;
    end
    mem[0] = 9'h011; mem[1] = 9'h012; mem[2] = 9'h013; mem[3] = {HALT, 5'h00};

    // Reset state
    repeat (3) tick();
    chk("rst_pc", {16'd0, if1.pc}, 32'd0);
    chk("rst_instr", {23'd0, if1.instr}, 32'd0);
    chk("rst_cnt", {16'd0, if1.instr_cnt}, 32'd0);
    chk("rst_flags", {29'd0, if1.imem_rd, if1.instr_valid, if1.done}, 32'd0);
    reset = 1;
    tick();

    // Straight-line program ending in HALT, LAT=1
    if1.start = 1;
    tick();
    if1.start = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_rd_%0d", i), {15'd0, if1.imem_rd, if1.imem_addr}, {15'd0, 1'b1, 16'(i)});
      tick();
      chk($sformatf("a_wait_%0d", i), {30'd0, if1.imem_rd, if1.instr_valid}, 32'd0);
      tick();
      chk($sformatf("a_exec_%0d", i), {6'd0, if1.instr_valid, if1.done, if1.instr, if1.instr_cnt},
          {6'd0, 1'b1, 1'b0, mem[i], 16'(i)});
      tick();
    end
    chk("a_done", {31'd0, if1.done}, 32'd1);
    chk("a_cnt", {16'd0, if1.instr_cnt}, 32'd4);
    chk("a_pc", {16'd0, if1.pc}, 32'd3);
    repeat (2) tick();
    chk("a_hold", {15'd0, if1.done, if1.pc}, {15'd0, 1'b1, 16'd3});

    // Branches, stall, and start held high during a run
    for (int i = 0; i < 5; i++) mem[i] = 9'h010 | 9'(i);
    mem[5] = {BRZ, 5'h01}; off_tab[5] = 8'hFE;
    mem[6] = {BRN, 5'h02}; off_tab[6] = 8'h04;
    mem[10] = {HALT, 5'h03};
    if1.z = 1; if1.neg = 1;
    if1.start = 1;
    tick();
    chk("b_restart", {if1.imem_rd, if1.done, if1.pc, if1.instr_cnt[13:0]},
        {1'b1, 1'b0, 16'd0, 14'd0});
    for (int i = 1; i < 6; i++) wait_rd1(16'(i));
    wait_rd1(16'd3);
    if1.z = 0;
    wait_rd1(16'd4);
    tick(); tick();
    if1.stall = 1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) if1.stall = 0;
      chk($sformatf("b_stall_%0d", c), {if1.instr_valid, if1.instr, if1.pc[5:0], if1.instr_cnt},
          {1'b1, mem[4], 6'd4, 16'd7});
      tick();
    end
    chk("b_after_stall", {14'd0, if1.instr_valid, if1.imem_rd, if1.imem_addr[7:0], if1.instr_cnt[7:0]},
        {14'd0, 1'b0, 1'b1, 8'd5, 8'd8});
    wait_rd1(16'd6);
    wait_rd1(16'd10);
    if1.start = 0;
    begin
      int n;
      n = 0;
      while (!if1.done && n < 40) begin
        tick();
        n++;
      end
    end
    chk("b_done", {31'd0, if1.done}, 32'd1);
    chk("b_cnt", {16'd0, if1.instr_cnt}, 32'd11);
    chk("b_pc", {16'd0, if1.pc}, 32'd10);

    // Jump wrap in both directions
    mem[0] = 9'h015; mem[1] = {JMP, 5'h04}; off_tab[1] = 8'hFD;
    mem[14] = 9'h016; mem[15] = {JMP, 5'h05}; off_tab[15] = 8'h01;
    if1.start = 1;
    tick();
    if1.start = 0;
    chk("c_start", {15'd0, if1.imem_rd, if1.pc}, {15'd0, 1'b1, 16'd0});
    wait_rd1(16'd1);
    wait_rd1(16'hFFFE);
    chk("c_pc_fffe", {16'd0, if1.pc}, 32'h0000FFFE);
    wait_rd1(16'hFFFF);
    wait_rd1(16'h0000);

    // LAT=3 capture/spacing, then reset mid-WAIT
    if3.start = 1;
    tick();
    if3.start = 0;
    chk("d_rd0", {15'd0, if3.imem_rd, if3.imem_addr}, {15'd0, 1'b1, 16'd0});
    tick();
    chk("d_w1", {23'd0, if3.instr}, 32'd0);
    tick();
    chk("d_w2", {23'd0, if3.instr}, 32'd0);
    tick();
    chk("d_w3", {30'd0, if3.imem_rd, if3.instr_valid}, 32'd0);
    tick();
    chk("d_exec", {22'd0, if3.instr_valid, if3.instr}, {22'd0, 1'b1, 9'h015});
    tick();
    chk("d_rd1", {15'd0, if3.imem_rd, if3.imem_addr}, {15'd0, 1'b1, 16'd1});
    repeat (5) tick();
    chk("d_rd_fffe", {15'd0, if3.imem_rd, if3.imem_addr}, {15'd0, 1'b1, 16'hFFFE});
    tick();
    #3 reset = 0;
    #1;
    chk("e_async_pc", {16'd0, if3.pc}, 32'd0);
    chk("e_async_flags", {29'd0, if3.imem_rd, if3.done, if3.instr_valid}, 32'd0);
    chk("e_async_regs", {7'd0, if3.instr, if3.instr_cnt}, 32'd0);
    tick();
    reset = 1;
    tick();
    tick();
    chk("e_late_data", {7'd0, if3.instr, if3.pc}, 32'd0);
    chk("e_idle", {29'd0, if3.imem_rd, if3.instr_valid, if3.done}, 32'd0);
    chk("e_dut1_idle", {15'd0, if1.imem_rd, if1.pc}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
